// File: rtl/capture_sequencer_pkg.sv
// rtl/capture_sequencer_pkg.sv - shared state/error encodings for the capture sequencer
//
// Purpose: state encodings (also driven onto the state output for LEDs/pmod),
//          error codes and a small helper used by the sequencer FSM.
// Ports:   none (package).
package capture_sequencer_pkg;

  typedef enum logic [2:0] {
    CS_STATE_POWER_DOWN = 3'd0,
    CS_STATE_CONFIGURE  = 3'd1,
    CS_STATE_GAP        = 3'd2,
    CS_STATE_TRANSFER   = 3'd3,
    CS_STATE_ERROR      = 3'd4
  } cs_state_e;

  typedef enum logic [1:0] {
    CS_ERR_NONE           = 2'd0,
    CS_ERR_CAMERA         = 2'd1,
    CS_ERR_CONFIG_TIMEOUT = 2'd2,
    CS_ERR_FRAME_TIMEOUT  = 2'd3
  } cs_err_e;

  localparam int CS_STATE_WIDTH = 3;
  localparam int CS_ERR_WIDTH   = 2;

  // States in which a camera_error report aborts the sequence.
  function automatic logic cs_watches_camera(input cs_state_e s);
    return (s == CS_STATE_CONFIGURE) || (s == CS_STATE_GAP) || (s == CS_STATE_TRANSFER);
  endfunction

endpackage

// File: rtl/capture_sequencer_if.sv
// rtl/capture_sequencer_if.sv - control/status bundle between the sequencer and the image path
//
// Purpose: groups the camera/LCD status inputs, user controls and the sequencer outputs.
// Modports:
//   master - the sequencer: reads controls/status, drives camera/LCD commands and status outputs
//   slave  - the surrounding system: drives controls/status, reads the sequencer outputs
interface capture_sequencer_if #(
  parameter int FrameCountWidth = 16
) ();
  import capture_sequencer_pkg::*;

  // user controls
  logic                       run_enable;
  logic                       snapshot;
  logic                       retry;
  // camera status
  logic                       camera_configuring;
  logic                       camera_idle;
  logic                       camera_busy;
  logic                       camera_error;
  logic                       camera_transfer;
  // LCD status
  logic                       lcd_running;
  logic                       lcd_busy;
  logic                       frame_done;
  // sequencer outputs
  logic                       camera_configure;
  logic                       camera_start;
  logic                       camera_stop;
  logic                       refresh;
  logic [CS_STATE_WIDTH-1:0]  state;
  logic                       error;
  logic [CS_ERR_WIDTH-1:0]    error_code;
  logic [FrameCountWidth-1:0] frame_count;

  modport master (
    input  run_enable, snapshot, retry,
    input  camera_configuring, camera_idle, camera_busy, camera_error, camera_transfer,
    input  lcd_running, lcd_busy, frame_done,
    output camera_configure, camera_start, camera_stop, refresh,
    output state, error, error_code, frame_count
  );

  modport slave (
    output run_enable, snapshot, retry,
    output camera_configuring, camera_idle, camera_busy, camera_error, camera_transfer,
    output lcd_running, lcd_busy, frame_done,
    input  camera_configure, camera_start, camera_stop, refresh,
    input  state, error, error_code, frame_count
  );

endinterface

// File: rtl/capture_sequencer_seq_timer.sv
// rtl/capture_sequencer_seq_timer.sv - loadable saturating down-counter with zero flag
//
// Purpose: one shared timer for every sequencer phase (power-up, config, gap, frame watchdog).
// Ports:
//   clock, reset_n  clock / asynchronous active-low reset (count returns to ResetValue)
//   load_i          load load_value_i this cycle (wins over dec_i)
//   load_value_i    value to load
//   dec_i           decrement by one, holding at zero
//   zero_o          count is zero
module seq_timer #(
  parameter int                    TimerWidth = 25,
  parameter logic [TimerWidth-1:0] ResetValue = '0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  load_i,
  input  logic [TimerWidth-1:0] load_value_i,
  input  logic                  dec_i,
  output logic                  zero_o
);

  logic [TimerWidth-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_value_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= ResetValue;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/capture_sequencer.sv
// rtl/capture_sequencer.sv - power-up, configure and refresh sequencer for the camera->LCD path
//
// Purpose: holds the camera in power-down, triggers configuration, waits for camera and LCD
//          readiness, then issues LCD refresh requests (continuous or snapshot) under a
//          per-frame watchdog. Errors park the FSM in ERROR until retry.
// Ports:
//   clock    system clock
//   reset_n  asynchronous active-low reset
//   bus      capture_sequencer_if.master: controls, camera/LCD status in; camera_configure,
//            camera_start, camera_stop, refresh, state, error, error_code, frame_count out
// All outputs are registered: a decision taken in cycle N is visible in cycle N+1.
module capture_sequencer
  import capture_sequencer_pkg::*;
#(
  parameter int PowerUpCount       = 2**22,
  parameter int ConfigTimeoutCount = 2**24,
  parameter int FrameGapCount      = 2**22,
  parameter int FrameTimeoutCount  = 2**24,
  parameter int TimerWidth         = 25,
  parameter int FrameCountWidth    = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  capture_sequencer_if.master bus
);

  localparam logic [TimerWidth-1:0] PowerUpLoad = TimerWidth'(PowerUpCount - 1);
  localparam logic [TimerWidth-1:0] ConfigLoad  = TimerWidth'(ConfigTimeoutCount - 1);
  localparam logic [TimerWidth-1:0] GapLoad     = TimerWidth'(FrameGapCount - 1);
  localparam logic [TimerWidth-1:0] FrameLoad   = TimerWidth'(FrameTimeoutCount - 1);

  cs_state_e                  state_q, state_d;
  cs_err_e                    error_code_q, error_code_d;
  logic                       camera_configure_q, camera_configure_d;
  logic                       camera_start_q, camera_start_d;
  logic                       camera_stop_q, camera_stop_d;
  logic                       refresh_q, refresh_d;
  logic                       error_q, error_d;
  logic                       snapshot_pending_q, snapshot_pending_d;
  logic [FrameCountWidth-1:0] frame_count_q, frame_count_d;

  logic                  timer_load;
  logic [TimerWidth-1:0] timer_load_value;
  logic                  timer_dec;
  logic                  timer_zero;

  logic    go_error;
  cs_err_e go_error_code;
  logic    path_ready;
  logic    path_quiet;

  seq_timer #(
    .TimerWidth (TimerWidth),
    .ResetValue (PowerUpLoad)
  ) u_timer (
    .clock        (clock),
    .reset_n      (reset_n),
    .load_i       (timer_load),
    .load_value_i (timer_load_value),
    .dec_i        (timer_dec),
    .zero_o       (timer_zero)
  );

  // Camera idle and LCD configured: safe to start streaming.
  assign path_ready = bus.lcd_running && bus.camera_idle && !bus.camera_busy &&
                      !bus.camera_configuring;
  // Nothing in flight anywhere in the pipeline: safe to request another frame.
  assign path_quiet = !bus.camera_busy && !bus.lcd_busy && !bus.camera_transfer;

  always_comb begin
    state_d            = state_q;
    error_code_d       = error_code_q;
    camera_configure_d = 1'b0;
    camera_start_d     = camera_start_q;
    camera_stop_d      = 1'b0;
    refresh_d          = 1'b0;
    error_d            = error_q;
    snapshot_pending_d = snapshot_pending_q;
    frame_count_d      = frame_count_q;
    timer_load         = 1'b0;
    timer_load_value   = '0;
    timer_dec          = 1'b0;
    go_error           = 1'b0;
    go_error_code      = CS_ERR_NONE;

    if (bus.snapshot && (state_q != CS_STATE_ERROR)) begin
      snapshot_pending_d = 1'b1;
    end

    if (cs_watches_camera(state_q) && bus.camera_error) begin
      go_error      = 1'b1;
      go_error_code = CS_ERR_CAMERA;
    end else begin
      case (state_q)
        CS_STATE_POWER_DOWN: begin
          if (timer_zero) begin
            camera_configure_d = 1'b1;
            timer_load         = 1'b1;
            timer_load_value   = ConfigLoad;
            state_d            = CS_STATE_CONFIGURE;
          end else begin
            timer_dec = 1'b1;
          end
        end

        CS_STATE_CONFIGURE: begin
          if (path_ready) begin
            camera_start_d   = 1'b1;
            timer_load       = 1'b1;
            timer_load_value = GapLoad;
            state_d          = CS_STATE_GAP;
          end else if (timer_zero) begin
            go_error      = 1'b1;
            go_error_code = CS_ERR_CONFIG_TIMEOUT;
          end else begin
            timer_dec = 1'b1;
          end
        end

        CS_STATE_GAP: begin
          if (timer_zero && (bus.run_enable || snapshot_pending_q) && path_quiet) begin
            refresh_d        = 1'b1;
            timer_load       = 1'b1;
            timer_load_value = FrameLoad;
            state_d          = CS_STATE_TRANSFER;
          end else begin
            timer_dec = 1'b1;
          end
        end

        CS_STATE_TRANSFER: begin
          // refresh_q high means this is the cycle the request goes out; a frame_done
          // seen now belongs to an earlier frame and must not be counted.
          if (bus.frame_done && !refresh_q) begin
            frame_count_d      = frame_count_q + 1'b1;
            // A snapshot arriving alongside the clearing frame_done is a new request.
            snapshot_pending_d = bus.snapshot;
            timer_load         = 1'b1;
            timer_load_value   = GapLoad;
            state_d            = CS_STATE_GAP;
          end else if (timer_zero) begin
            go_error      = 1'b1;
            go_error_code = CS_ERR_FRAME_TIMEOUT;
          end else begin
            timer_dec = 1'b1;
          end
        end

        CS_STATE_ERROR: begin
          if (bus.retry) begin
            error_d          = 1'b0;
            error_code_d     = CS_ERR_NONE;
            timer_load       = 1'b1;
            timer_load_value = PowerUpLoad;
            state_d          = CS_STATE_POWER_DOWN;
          end
        end

        default: begin
          state_d = CS_STATE_POWER_DOWN;
        end
      endcase
    end

    if (go_error) begin
      state_d        = CS_STATE_ERROR;
      camera_start_d = 1'b0;
      camera_stop_d  = 1'b1;
      error_d        = 1'b1;
      error_code_d   = go_error_code;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q            <= CS_STATE_POWER_DOWN;
      error_code_q       <= CS_ERR_NONE;
      camera_configure_q <= 1'b0;
      camera_start_q     <= 1'b0;
      camera_stop_q      <= 1'b0;
      refresh_q          <= 1'b0;
      error_q            <= 1'b0;
      snapshot_pending_q <= 1'b0;
      frame_count_q      <= '0;
    end else begin
      state_q            <= state_d;
      error_code_q       <= error_code_d;
      camera_configure_q <= camera_configure_d;
      camera_start_q     <= camera_start_d;
      camera_stop_q      <= camera_stop_d;
      refresh_q          <= refresh_d;
      error_q            <= error_d;
      snapshot_pending_q <= snapshot_pending_d;
      frame_count_q      <= frame_count_d;
    end
  end

  assign bus.camera_configure = camera_configure_q;
  assign bus.camera_start     = camera_start_q;
  assign bus.camera_stop      = camera_stop_q;
  assign bus.refresh          = refresh_q;
  assign bus.state            = state_q;
  assign bus.error            = error_q;
  assign bus.error_code       = error_code_q;
  assign bus.frame_count      = frame_count_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// tb/tb_capture_sequencer.sv - directed table-driven bench for capture_sequencer
module tb_capture_sequencer;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  always #5 clock = ~clock;

  capture_sequencer_if #(.FrameCountWidth(16)) bus ();

  capture_sequencer #(
    .PowerUpCount       (8),
    .ConfigTimeoutCount (64),
    .FrameGapCount      (4),
    .FrameTimeoutCount  (32),
    .TimerWidth         (25),
    .FrameCountWidth    (16)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int         n;
    logic       run, snap, retry, cerr, lcdr, lbusy, fd;
    logic [2:0] st;
    logic       refr, cfg, start, stop, err;
    logic [1:0] code;
    int         cnt;
  } vec_t;

  vec_t tbl[43];

  int checks = 0;
  int errors = 0;
  int refresh_seen = 0;
  int configure_seen = 0;
  int stop_seen = 0;

  function automatic vec_t mk(input int n, input logic run, snap, retry, cerr, lcdr, lbusy, fd,
                              input logic [2:0] st, input logic refr, cfg, start, stop, err,
                              input logic [1:0] code, input int cnt);
    vec_t v;
    v.n = n; v.run = run; v.snap = snap; v.retry = retry; v.cerr = cerr;
    v.lcdr = lcdr; v.lbusy = lbusy; v.fd = fd;
    v.st = st; v.refr = refr; v.cfg = cfg; v.start = start; v.stop = stop; v.err = err;
    v.code = code; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance n clock edges; sample 1 time unit after each edge and tally output pulses.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
      if (bus.refresh) refresh_seen++;
      if (bus.camera_configure) configure_seen++;
      if (bus.camera_stop) stop_seen++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " state"}, 32'(bus.state), 0);
    check({tag, " configure"}, 32'(bus.camera_configure), 0);
    check({tag, " start"}, 32'(bus.camera_start), 0);
    check({tag, " stop"}, 32'(bus.camera_stop), 0);
    check({tag, " refresh"}, 32'(bus.refresh), 0);
    check({tag, " error"}, 32'(bus.error), 0);
    check({tag, " code"}, 32'(bus.error_code), 0);
    check({tag, " count"}, 32'(bus.frame_count), 0);
  endtask

  initial begin
    bus.run_enable = 0; bus.snapshot = 0; bus.retry = 0;
    bus.camera_configuring = 0; bus.camera_idle = 1; bus.camera_busy = 0;
    bus.camera_error = 0; bus.camera_transfer = 0;
    bus.lcd_running = 1; bus.lcd_busy = 0; bus.frame_done = 0;

    //          n   run snp rty cer lcr lbs fd   st rf cf st sp er cd cnt
    tbl[0]  = mk(7,   0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1,   0, 0, 0, 0, 1, 0, 0,   1, 0, 1, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1,   0, 0, 0, 0, 1, 0, 0,   2, 0, 0, 1, 0, 0, 0, 0);
    tbl[3]  = mk(3,   1, 0, 0, 0, 1, 0, 0,   2, 0, 0, 1, 0, 0, 0, 0);
    tbl[4]  = mk(1,   1, 0, 0, 0, 1, 1, 0,   2, 0, 0, 1, 0, 0, 0, 0);
    tbl[5]  = mk(1,   1, 0, 0, 0, 1, 0, 0,   3, 1, 0, 1, 0, 0, 0, 0);
    tbl[6]  = mk(9,   1, 0, 0, 0, 1, 0, 0,   3, 0, 0, 1, 0, 0, 0, 0);
    tbl[7]  = mk(1,   1, 0, 0, 0, 1, 0, 1,   2, 0, 0, 1, 0, 0, 0, 1);
    tbl[8]  = mk(3,   1, 0, 0, 0, 1, 0, 0,   2, 0, 0, 1, 0, 0, 0, 1);
    tbl[9]  = mk(1,   1, 0, 0, 0, 1, 0, 0,   3, 1, 0, 1, 0, 0, 0, 1);
    tbl[10] = mk(1,   1, 0, 0, 0, 1, 0, 1,   3, 0, 0, 1, 0, 0, 0, 1);
    tbl[11] = mk(8,   1, 0, 0, 0, 1, 0, 0,   3, 0, 0, 1, 0, 0, 0, 1);
    tbl[12] = mk(1,   1, 0, 0, 0, 1, 0, 1,   2, 0, 0, 1, 0, 0, 0, 2);
    tbl[13] = mk(3,   1, 0, 0, 0, 1, 0, 0,   2, 0, 0, 1, 0, 0, 0, 2);
    tbl[14] = mk(1,   1, 0, 0, 0, 1, 0, 0,   3, 1, 0, 1, 0, 0, 0, 2);
    tbl[15] = mk(9,   1, 0, 0, 0, 1, 0, 0,   3, 0, 0, 1, 0, 0, 0, 2);
    tbl[16] = mk(1,   0, 0, 0, 0, 1, 0, 1,   2, 0, 0, 1, 0, 0, 0, 3);
    tbl[17] = mk(20,  0, 0, 0, 0, 1, 0, 0,   2, 0, 0, 1, 0, 0, 0, 3);
    tbl[18] = mk(1,   0, 1, 0, 0, 1, 0, 0,   2, 0, 0, 1, 0, 0, 0, 3);
    tbl[19] = mk(1,   0, 0, 0, 0, 1, 0, 0,   3, 1, 0, 1, 0, 0, 0, 3);
    tbl[20] = mk(5,   0, 0, 0, 0, 1, 0, 0,   3, 0, 0, 1, 0, 0, 0, 3);
    tbl[21] = mk(1,   0, 1, 0, 0, 1, 0, 1,   2, 0, 0, 1, 0, 0, 0, 4);
    tbl[22] = mk(3,   0, 0, 0, 0, 1, 0, 0,   2, 0, 0, 1, 0, 0, 0, 4);
    tbl[23] = mk(1,   0, 0, 0, 0, 1, 0, 0,   3, 1, 0, 1, 0, 0, 0, 4);
    tbl[24] = mk(4,   0, 0, 0, 0, 1, 0, 0,   3, 0, 0, 1, 0, 0, 0, 4);
    tbl[25] = mk(1,   0, 0, 0, 0, 1, 0, 1,   2, 0, 0, 1, 0, 0, 0, 5);
    tbl[26] = mk(100, 0, 0, 0, 0, 1, 0, 0,   2, 0, 0, 1, 0, 0, 0, 5);
    tbl[27] = mk(1,   1, 0, 0, 0, 1, 0, 0,   3, 1, 0, 1, 0, 0, 0, 5);
    tbl[28] = mk(31,  0, 0, 0, 0, 1, 0, 0,   3, 0, 0, 1, 0, 0, 0, 5);
    tbl[29] = mk(1,   0, 0, 0, 0, 1, 0, 0,   4, 0, 0, 0, 1, 1, 3, 5);
    tbl[30] = mk(1,   0, 1, 0, 0, 1, 0, 0,   4, 0, 0, 0, 0, 1, 3, 5);
    tbl[31] = mk(1,   0, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 5);
    tbl[32] = mk(7,   0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 5);
    tbl[33] = mk(1,   0, 0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 0, 0, 0, 5);
    tbl[34] = mk(63,  0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 5);
    tbl[35] = mk(1,   0, 0, 0, 0, 0, 0, 0,   4, 0, 0, 0, 1, 1, 2, 5);
    tbl[36] = mk(1,   0, 0, 1, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0, 5);
    tbl[37] = mk(8,   0, 0, 0, 0, 1, 0, 0,   1, 0, 1, 0, 0, 0, 0, 5);
    tbl[38] = mk(1,   0, 0, 0, 0, 1, 0, 0,   2, 0, 0, 1, 0, 0, 0, 5);
    tbl[39] = mk(3,   0, 0, 0, 0, 1, 0, 0,   2, 0, 0, 1, 0, 0, 0, 5);
    tbl[40] = mk(1,   0, 0, 0, 0, 1, 0, 0,   2, 0, 0, 1, 0, 0, 0, 5);
    tbl[41] = mk(1,   0, 0, 0, 1, 1, 0, 0,   4, 0, 0, 0, 1, 1, 1, 5);
    tbl[42] = mk(1,   0, 0, 0, 0, 1, 0, 0,   4, 0, 0, 0, 0, 1, 1, 5);

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;

    // Cycle-by-cycle script through power-up, run, snapshot, timeouts and errors
    for (int i = 0; i < 43; i++) begin
      bus.run_enable   = tbl[i].run;
      bus.snapshot     = tbl[i].snap;
      bus.retry        = tbl[i].retry;
      bus.camera_error = tbl[i].cerr;
      bus.lcd_running  = tbl[i].lcdr;
      bus.lcd_busy     = tbl[i].lbusy;
      bus.frame_done   = tbl[i].fd;
      if (tbl[i].n > 1) begin
        step(1);
        // Pulse-type inputs only last one cycle; the rest of the row runs quiet.
        bus.snapshot = 0; bus.retry = 0; bus.frame_done = 0;
        step(tbl[i].n - 1);
      end else begin
        step(1);
      end
      check($sformatf("row%0d state", i), 32'(bus.state), 32'(tbl[i].st));
      check($sformatf("row%0d refresh", i), 32'(bus.refresh), 32'(tbl[i].refr));
      check($sformatf("row%0d configure", i), 32'(bus.camera_configure), 32'(tbl[i].cfg));
      check($sformatf("row%0d start", i), 32'(bus.camera_start), 32'(tbl[i].start));
      check($sformatf("row%0d stop", i), 32'(bus.camera_stop), 32'(tbl[i].stop));
      check($sformatf("row%0d error", i), 32'(bus.error), 32'(tbl[i].err));
      check($sformatf("row%0d code", i), 32'(bus.error_code), 32'(tbl[i].code));
      check($sformatf("row%0d count", i), 32'(bus.frame_count), 32'(tbl[i].cnt));
      bus.snapshot = 0; bus.retry = 0; bus.frame_done = 0; bus.camera_error = 0;
    end

    check("refresh pulses total", 32'(refresh_seen), 6);
    check("configure pulses total", 32'(configure_seen), 3);
    check("stop pulses total", 32'(stop_seen), 3);

    // Asynchronous reset while a frame is in flight
    bus.retry = 1; bus.run_enable = 1;
    step(1);
    bus.retry = 0;
    begin
      int budget;
      budget = 0;
      while (!bus.refresh && budget < 40) begin
        step(1);
        budget++;
      end
      check("mid-transfer refresh reached", 32'(bus.refresh), 1);
    end
    step(5);
    check("mid-transfer state", 32'(bus.state), 3);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async reset");
    @(posedge clock);
    #1;
    bus.run_enable = 0;
    reset_n = 1'b1;
    step(7);
    check("restart configure early", 32'(bus.camera_configure), 0);
    check("restart state early", 32'(bus.state), 0);
    step(1);
    check("restart configure", 32'(bus.camera_configure), 1);
    check("restart state", 32'(bus.state), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
